solver_dispatch: RTL and testbench

Host-side driver for one fractal solver core. Accepts a job (cre and cim limbs plus a tag) as a valid/ready beat stream, writes iteration limit, limb count and coordinates into the solver, and pulses start. It then waits for the solver's completion flag and returns the iteration count and tag as a valid/ready result. It sits between the job distributor and a single solver instance, and is the only agent driving that solver's load port.

---
 rtl/solver_dispatch.sv | 147 ++++++++++++++
 tb/tb_solver_dispatch.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/solver_dispatch.sv
// solver_dispatch: host-side driver for one fractal solver core.
// Takes a job as a stream of coordinate limbs (cre then cim, MS limb first),
// programs the solver's limb count, iteration limit and coordinates, pulses
// start, waits for the sticky done flag and returns count + tag as a result.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for the first job beat; latches cfg on job_valid
// CONFIG    | writes limb count and iteration limit into the solver
// LOAD      | accepts 2N job beats and writes them as coordinate limbs
// START     | one-cycle solver start pulse
// WAIT_DONE | waiting for the solver done flag
// RESULT    | result presented until the consumer accepts it
module solver_dispatch #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_BITS       = 32,
  parameter int TAG_BITS        = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [LIMB_INDEX_BITS-1:0] cfg_num_limbs,
  input  logic [15:0]                cfg_iter_lim,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [LIMB_BITS-1:0]       job_data,
  input  logic [TAG_BITS-1:0]        job_tag,
  output logic                       slv_wr_en,
  output logic                       slv_wr_ind,
  output logic [LIMB_INDEX_BITS-1:0] slv_wr_addr,
  output logic [LIMB_BITS-1:0]       slv_wr_data,
  output logic                       slv_wr_num_limbs_en,
  output logic [LIMB_INDEX_BITS-1:0] slv_num_limbs_data,
  output logic                       slv_wr_iter_lim_en,
  output logic [15:0]                slv_iter_lim_data,
  output logic                       slv_start,
  input  logic                       slv_out_ready,
  input  logic [15:0]                slv_iteration_count,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [15:0]                res_count,
  output logic                       res_escaped,
  output logic [TAG_BITS-1:0]        res_tag,
  output logic                       busy
);

  typedef enum logic [2:0] {IDLE, CONFIG, LOAD, START, WAIT_DONE, RESULT} state_t;

  localparam logic [LIMB_INDEX_BITS-1:0] ONE_N = LIMB_INDEX_BITS'(1);
  localparam logic [LIMB_INDEX_BITS:0]   ONE_K = (LIMB_INDEX_BITS + 1)'(1);

  state_t                     state;
  logic [LIMB_INDEX_BITS-1:0] n_lat;
  logic [15:0]                iter_lat;
  logic [LIMB_INDEX_BITS:0]   k;
  logic [LIMB_INDEX_BITS:0]   n_ext;
  logic [LIMB_INDEX_BITS:0]   last_beat;
  logic [LIMB_INDEX_BITS-1:0] k_low;
  logic                       in_cim;

  // Beat index decode: k counts 0..2N-1, so it needs one bit more than N.
  // The cim address 2N-1-k is rewritten as (N-1)-(k-N) so it stays in the
  // narrow limb-address width without losing the modulo behaviour.
  assign n_ext     = {1'b0, n_lat};
  assign last_beat = (n_ext << 1) - ONE_K;
  assign in_cim    = (k >= n_ext);
  assign k_low     = k[LIMB_INDEX_BITS-1:0];

  assign slv_wr_en          = job_ready & job_valid;
  assign slv_wr_ind         = in_cim;
  assign slv_wr_addr        = n_lat - ONE_N - (in_cim ? (k_low - n_lat) : k_low);
  assign slv_wr_data        = job_data;
  assign slv_num_limbs_data = n_lat;
  assign slv_iter_lim_data  = iter_lat;

  // Sequencer: state, latched job parameters and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      n_lat               <= '0;
      iter_lat            <= '0;
      k                   <= '0;
      job_ready           <= 1'b0;
      slv_wr_num_limbs_en <= 1'b0;
      slv_wr_iter_lim_en  <= 1'b0;
      slv_start           <= 1'b0;
      res_valid           <= 1'b0;
      res_count           <= '0;
      res_escaped         <= 1'b0;
      res_tag             <= '0;
      busy                <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (job_valid) begin
            n_lat               <= (cfg_num_limbs == '0) ? ONE_N : cfg_num_limbs;
            iter_lat            <= cfg_iter_lim;
            slv_wr_num_limbs_en <= 1'b1;
            slv_wr_iter_lim_en  <= 1'b1;
            busy                <= 1'b1;
            state               <= CONFIG;
          end
        end
        CONFIG: begin
          slv_wr_num_limbs_en <= 1'b0;
          slv_wr_iter_lim_en  <= 1'b0;
          job_ready           <= 1'b1;
          k                   <= '0;
          state               <= LOAD;
        end
        LOAD: begin
          if (job_valid) begin
            if (k == '0) res_tag <= job_tag;
            if (k == last_beat) begin
              k         <= '0;
              job_ready <= 1'b0;
              slv_start <= 1'b1;
              state     <= START;
            end else begin
              k <= k + ONE_K;
            end
          end
        end
        START: begin
          slv_start <= 1'b0;
          state     <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (slv_out_ready) begin
            res_count   <= slv_iteration_count;
            res_escaped <= (slv_iteration_count != 16'hFFFF);
            res_valid   <= 1'b1;
            state       <= RESULT;
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_solver_dispatch.sv
// Testbench for solver_dispatch: directed jobs against a small solver model,
// with expected limb writes, config writes and results kept in queues.
module tb_solver_dispatch;

  typedef struct packed { logic ind; logic [5:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [15:0] cnt; logic esc; logic [7:0] tag; } res_t;
  typedef struct packed { logic [5:0] n; logic [15:0] lim; } cfg_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  cfg_num_limbs;
  logic [15:0] cfg_iter_lim;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_data;
  logic [7:0]  job_tag;
  logic        slv_wr_en, slv_wr_ind;
  logic [5:0]  slv_wr_addr;
  logic [31:0] slv_wr_data;
  logic        slv_wr_num_limbs_en;
  logic [5:0]  slv_num_limbs_data;
  logic        slv_wr_iter_lim_en;
  logic [15:0] slv_iter_lim_data;
  logic        slv_start;
  logic        slv_out_ready;
  logic [15:0] slv_iteration_count;
  logic        res_valid, res_ready;
  logic [15:0] res_count;
  logic        res_escaped;
  logic [7:0]  res_tag;
  logic        busy;

  wr_t  exp_wr[$];
  res_t exp_res[$];
  cfg_t exp_cfg[$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, starts = 0, exp_starts = 0, start_cyc = 0, sv_cnt = 0;

  solver_dispatch dut (
    .clock(clock), .reset(reset), .cfg_num_limbs(cfg_num_limbs), .cfg_iter_lim(cfg_iter_lim),
    .job_valid(job_valid), .job_ready(job_ready), .job_data(job_data), .job_tag(job_tag),
    .slv_wr_en(slv_wr_en), .slv_wr_ind(slv_wr_ind), .slv_wr_addr(slv_wr_addr),
    .slv_wr_data(slv_wr_data), .slv_wr_num_limbs_en(slv_wr_num_limbs_en),
    .slv_num_limbs_data(slv_num_limbs_data), .slv_wr_iter_lim_en(slv_wr_iter_lim_en),
    .slv_iter_lim_data(slv_iter_lim_data), .slv_start(slv_start),
    .slv_out_ready(slv_out_ready), .slv_iteration_count(slv_iteration_count),
    .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count),
    .res_escaped(res_escaped), .res_tag(res_tag), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Solver model: done flag cleared on the start edge, set 3 cycles later.
  always @(posedge clock) begin
    if (reset) begin
      slv_out_ready <= 1'b0;
      sv_cnt        <= 0;
    end else if (slv_start) begin
      slv_out_ready <= 1'b0;
      sv_cnt        <= 3;
    end else if (sv_cnt != 0) begin
      sv_cnt <= sv_cnt - 1;
      if (sv_cnt == 1) slv_out_ready <= 1'b1;
    end
  end

  // Monitor: pop expectations as the DUT writes the solver or hands off results.
  always @(negedge clock) begin
    wr_t w;
    res_t r;
    cfg_t c;
    if (slv_start) begin
      starts++;
      start_cyc = cyc;
    end
    if (slv_wr_en) begin
      n_cmp++;
      assert (exp_wr.size() != 0) else begin
        n_err++;
        $error("FAIL wr_extra: got ind=%0d addr=%0d data=%0h, required no write",
               slv_wr_ind, slv_wr_addr, slv_wr_data);
      end
      if (exp_wr.size() != 0) begin
        w = exp_wr.pop_front();
        n_cmp++;
        assert ({slv_wr_ind, slv_wr_addr, slv_wr_data} === w) else begin
          n_err++;
          $error("FAIL wr: got ind=%0d addr=%0d data=%0h, required ind=%0d addr=%0d data=%0h",
                 slv_wr_ind, slv_wr_addr, slv_wr_data, w.ind, w.addr, w.data);
        end
      end
    end
    if (slv_wr_num_limbs_en) begin
      n_cmp++;
      c = (exp_cfg.size() != 0) ? exp_cfg.pop_front() : '1;
      assert ({slv_wr_iter_lim_en, slv_num_limbs_data, slv_iter_lim_data} === {1'b1, c.n, c.lim}) else begin
        n_err++;
        $error("FAIL cfg: got en=%0d n=%0d lim=%0d, required en=1 n=%0d lim=%0d",
               slv_wr_iter_lim_en, slv_num_limbs_data, slv_iter_lim_data, c.n, c.lim);
      end
    end
    if (res_valid && res_ready) begin
      n_cmp++;
      r = (exp_res.size() != 0) ? exp_res.pop_front() : '1;
      assert ({res_count, res_escaped, res_tag} === r) else begin
        n_err++;
        $error("FAIL res: got cnt=%0d esc=%0d tag=%0h, required cnt=%0d esc=%0d tag=%0h",
               res_count, res_escaped, res_tag, r.cnt, r.esc, r.tag);
      end
    end
  end

  // Queue the expectations of one job and drive its beats (stop_after < 0: all).
  task automatic load_job(input int ncfg, input logic [15:0] lim, input logic [7:0] tag,
                          input bit gaps, input bit seq_data, input logic [15:0] result,
                          input int stop_after, input bit chg, input logic [15:0] new_lim,
                          output int c0);
    int n, nb;
    bit acc;
    logic [31:0] d[$];
    wr_t w;
    res_t r;
    n = (ncfg == 0) ? 1 : ncfg;
    cfg_num_limbs = 6'(ncfg);
    cfg_iter_lim  = lim;
    exp_cfg.push_back({6'(n), lim});
    for (int i = 0; i < 2 * n; i++) begin
      d.push_back(seq_data ? 32'hA + 32'(i) : $urandom);
      w.ind  = (i >= n);
      w.addr = (i < n) ? 6'(n - 1 - i) : 6'(2 * n - 1 - i);
      w.data = d[i];
      exp_wr.push_back(w);
    end
    nb = (stop_after < 0) ? 2 * n : stop_after;
    if (stop_after < 0) begin
      r.cnt = result;
      r.esc = (result != 16'hFFFF);
      r.tag = tag;
      exp_res.push_back(r);
      exp_starts++;
    end
    slv_iteration_count = result;
    @(posedge clock); #1;
    c0 = cyc;
    for (int i = 0; i < nb; i++) begin
      job_valid = 1'b1;
      job_data  = d[i];
      job_tag   = (i == 0) ? tag : ~tag;
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
        @(negedge clock);
        acc = job_ready;
        @(posedge clock); #1;
      end
      n_cmp++;
      assert (acc) else begin
        n_err++;
        $error("FAIL beat_timeout: got job_ready=0 for beat %0d, required 1", i);
      end
      if (chg && i == 0) cfg_iter_lim = new_lim;
      job_valid = 1'b0;
      if (gaps) begin
        @(posedge clock); #1;
      end
    end
    job_valid = 1'b0;
  endtask

  // Wait for the result, hold it for 'hold' cycles checking stability, then accept.
  task automatic finish_job(input int hold);
    bit got;
    res_t e;
    got = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clock);
      got = res_valid;
    end
    n_cmp++;
    assert (got) else begin
      n_err++;
      $error("FAIL res_timeout: got res_valid=0, required 1");
    end
    e = (exp_res.size() != 0) ? exp_res[0] : '1;
    for (int j = 0; j < hold; j++) begin
      n_cmp++;
      assert ({res_valid, res_count, res_escaped, res_tag} === {1'b1, e}) else begin
        n_err++;
        $error("FAIL res_hold: got v=%0d cnt=%0d esc=%0d tag=%0h, required v=1 cnt=%0d esc=%0d tag=%0h",
               res_valid, res_count, res_escaped, res_tag, e.cnt, e.esc, e.tag);
      end
      @(negedge clock);
    end
    @(posedge clock); #1;
    res_ready = 1'b1;
    @(posedge clock); #1;
    res_ready = 1'b0;
    @(negedge clock);
    n_cmp++;
    assert ({busy, res_valid} === 2'b00) else begin
      n_err++;
      $error("FAIL idle_after_res: got busy=%0d res_valid=%0d, required 0 0", busy, res_valid);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed sequence.
  initial begin
    int c0, s0;
    reset = 1'b1;
    cfg_num_limbs = '0;
    cfg_iter_lim = '0;
    job_valid = 1'b0;
    job_data = '0;
    job_tag = '0;
    res_ready = 1'b0;
    slv_iteration_count = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    assert ({job_ready, slv_wr_num_limbs_en, slv_wr_iter_lim_en, slv_start, res_valid, busy,
             res_count, res_escaped, res_tag} === '0) else begin
      n_err++;
      $error("FAIL reset_state: got rdy=%0d cfg=%0d%0d st=%0d rv=%0d busy=%0d cnt=%0d esc=%0d tag=%0h, required all 0",
             job_ready, slv_wr_num_limbs_en, slv_wr_iter_lim_en, slv_start, res_valid, busy,
             res_count, res_escaped, res_tag);
    end
    reset = 1'b0;

    // N=2, continuous beats, latency to start.
    load_job(2, 16'd100, 8'h5A, 1'b0, 1'b1, 16'd37, -1, 1'b0, 16'd0, c0);
    finish_job(0);
    n_cmp++;
    assert (start_cyc - c0 == 6) else begin
      n_err++;
      $error("FAIL start_latency: got %0d cycles, required 6", start_cyc - c0);
    end

    // Same job with gaps; later beats carry a wrong tag.
    load_job(2, 16'd100, 8'h5A, 1'b1, 1'b1, 16'd37, -1, 1'b0, 16'd0, c0);
    finish_job(0);

    // Limit reached, consumer stalls 5 cycles.
    load_job(3, 16'd200, 8'h33, 1'b0, 1'b0, 16'hFFFF, -1, 1'b0, 16'd0, c0);
    finish_job(5);

    // cfg_num_limbs = 0 behaves as one limb.
    load_job(0, 16'd50, 8'h11, 1'b0, 1'b0, 16'd12, -1, 1'b0, 16'd0, c0);
    finish_job(1);

    // Reset after 3 of 4 beats abandons the job.
    s0 = starts;
    load_job(2, 16'd100, 8'h77, 1'b0, 1'b0, 16'd9, 3, 1'b0, 16'd0, c0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    assert ({job_ready, slv_wr_en, slv_wr_num_limbs_en, slv_wr_iter_lim_en, slv_start, res_valid,
             busy, res_count, res_escaped, res_tag} === '0) else begin
      n_err++;
      $error("FAIL reset_midjob: got rdy=%0d st=%0d rv=%0d busy=%0d cnt=%0d tag=%0h, required all 0",
             job_ready, slv_start, res_valid, busy, res_count, res_tag);
    end
    exp_wr.delete();
    repeat (10) @(negedge clock);
    n_cmp++;
    assert (starts == s0 && res_valid === 1'b0) else begin
      n_err++;
      $error("FAIL abandoned_job: got starts=%0d rv=%0d, required starts=%0d rv=0", starts, res_valid, s0);
    end
    load_job(2, 16'd100, 8'h78, 1'b0, 1'b0, 16'd40, -1, 1'b0, 16'd0, c0);
    finish_job(0);

    // Back-to-back jobs; iteration limit changed during the first job's LOAD.
    load_job(4, 16'd300, 8'h21, 1'b0, 1'b0, 16'd500, -1, 1'b1, 16'd301, c0);
    finish_job(0);
    load_job(4, 16'd301, 8'h22, 1'b0, 1'b0, 16'hFFFF, -1, 1'b0, 16'd0, c0);
    finish_job(0);

    // Maximum limb count.
    load_job(63, 16'd1000, 8'hC3, 1'b0, 1'b0, 16'd1, -1, 1'b0, 16'd0, c0);
    finish_job(0);

    repeat (3) @(negedge clock);
    n_cmp++;
    assert (exp_wr.size() == 0 && exp_res.size() == 0 && exp_cfg.size() == 0 && starts == exp_starts) else begin
      n_err++;
      $error("FAIL leftovers: got wr=%0d res=%0d cfg=%0d starts=%0d, required 0 0 0 starts=%0d",
             exp_wr.size(), exp_res.size(), exp_cfg.size(), starts, exp_starts);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
